// File: rtl/denise_palette_sequencer.sv
// Write sequencer in front of the Denise 32-entry colour table: merges CPU/copper
// colour register writes with a streamed bulk palette load, one write per 7 MHz slot.
module denise_palette_sequencer #(
  parameter logic [8:0] COLORBASE = 9'h180,
  parameter logic [8:0] NOOP      = 9'h1FE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk7_en,
  input  logic [8:1]  reg_address_in,
  input  logic [11:0] data_in,
  input  logic        start,
  input  logic [4:0]  start_index,
  input  logic [4:0]  start_count,
  input  logic        abort,
  input  logic        st_valid,
  input  logic [11:0] st_data,
  output logic        st_ready,
  output logic [8:1]  col_address,
  output logic [11:0] col_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rem_q, rem_d;
  logic        cpu_hit;
  logic        xfer;
  logic [8:1]  addr_d;
  logic [11:0] data_d;

  // Stream handshake: a transfer happens only when st_valid and st_ready are both
  // high in a clk7_en cycle; st_ready already folds in the slot, CPU and abort.
  assign cpu_hit   = (reg_address_in[8:6] == COLORBASE[8:6]);
  assign st_ready  = (state_q == LOAD) && clk7_en && !cpu_hit && !abort;
  assign xfer      = st_valid && st_ready;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == FIN);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    if (clk7_en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_d   = start_index;
            rem_d   = start_count;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state_d = IDLE;
          end else if (xfer) begin
            idx_d = idx_q + 5'd1;
            if (rem_q == 5'd0) state_d = FIN;
            else               rem_d   = rem_q - 5'd1;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // CPU always owns the slot it hits; the stream only fills otherwise-empty slots.
  always_comb begin
    addr_d = NOOP[8:1];
    data_d = col_data;
    if (cpu_hit) begin
      addr_d = reg_address_in;
      data_d = data_in;
    end else if (xfer) begin
      addr_d = {COLORBASE[8:6], idx_q};
      data_d = st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      rem_q       <= 5'd0;
      col_address <= NOOP[8:1];
      col_data    <= 12'd0;
    end else if (clk7_en) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      col_address <= addr_d;
      col_data    <= data_d;
    end
  end

endmodule

// File: tb/tb_denise_palette_sequencer.sv
// Bench for denise_palette_sequencer: queue-based load model checked every cycle,
// plus directed slot-by-slot literal expectations.
module tb_denise_palette_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk7_en = 1'b0;
  logic [8:1]  reg_address_in;
  logic [11:0] data_in;
  logic        start;
  logic [4:0]  start_index;
  logic [4:0]  start_count;
  logic        abort;
  logic        st_valid;
  logic [11:0] st_data;
  logic        st_ready;
  logic [8:1]  col_address;
  logic [11:0] col_data;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic last_rdy;

  denise_palette_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk7_en(clk7_en),
    .reg_address_in(reg_address_in), .data_in(data_in),
    .start(start), .start_index(start_index), .start_count(start_count),
    .abort(abort), .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
    .col_address(col_address), .col_data(col_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:1] a9(input logic [8:0] a);
    return a[8:1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: pending entries of the active load kept as a queue of colour indices
  logic [4:0]  exp_q[$];
  bit          m_loading;
  bit          m_fin;
  logic [8:1]  m_addr;
  logic [11:0] m_data;

  function automatic bit m_cpu();
    return (reg_address_in >= a9(9'h180)) && (reg_address_in <= a9(9'h1BE));
  endfunction

  task automatic model_reset();
    m_loading = 1'b0;
    m_fin     = 1'b0;
    exp_q.delete();
    m_addr    = 8'hFF;
    m_data    = 12'd0;
  endtask

  task automatic model_step();
    bit cpu;
    bit xf;
    logic [8:0] full;
    cpu = m_cpu();
    xf  = m_loading && !cpu && !abort && st_valid;
    if (cpu) begin
      m_addr = reg_address_in;
      m_data = data_in;
    end else if (xf) begin
      full   = 9'h180 + 9'(2 * int'(exp_q[0]));
      m_addr = full[8:1];
      m_data = st_data;
    end else begin
      m_addr = 8'hFF;
    end
    if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_loading) begin
      if (abort) begin
        m_loading = 1'b0;
        exp_q.delete();
      end else if (xf) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_loading = 1'b0;
          m_fin     = 1'b1;
        end
      end
    end else if (start) begin
      for (int i = 0; i <= int'(start_count); i++) exp_q.push_back(5'(int'(start_index) + i));
      m_loading = 1'b1;
    end
  endtask

  // compare process
  always @(negedge clk) begin
    #2;
    check("col_address", 32'(col_address), 32'(m_addr));
    check("col_data", 32'(col_data), 32'(m_data));
    check("busy", 32'(busy), 32'(m_loading));
    check("done", 32'(done), 32'(m_fin));
    check("st_ready", 32'(st_ready), 32'(clk7_en && m_loading && !m_cpu() && !abort));
  end

  // driver: one 7 MHz slot = four clk cycles, enable on the first
  task automatic slot();
    @(negedge clk);
    clk7_en = 1'b1;
    #1 last_rdy = st_ready;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    clk7_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic begin_load(input logic [4:0] si, input logic [4:0] sc);
    start_index = si;
    start_count = sc;
    start = 1'b1;
    slot();
    start = 1'b0;
  endtask

  int k;
  bit pat [7] = '{1, 0, 1, 0, 0, 1, 1};

  initial begin
    reg_address_in = 8'h00;
    data_in = 12'd0;
    start = 1'b0;
    start_index = 5'd0;
    start_count = 5'd0;
    abort = 1'b0;
    st_valid = 1'b0;
    st_data = 12'd0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(col_address), 32'hFF);
    check("rst_data", 32'(col_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(st_ready), 32'h0);
    rst_n = 1'b1;
    slot();

    // CPU passthrough and non-colour addresses
    reg_address_in = a9(9'h18A); data_in = 12'hF00; slot();
    check("cpu_18a_addr", 32'(col_address), 32'hC5);
    check("cpu_18a_data", 32'(col_data), 32'hF00);
    reg_address_in = a9(9'h100); data_in = 12'h123; slot();
    check("cpu_100_addr", 32'(col_address), 32'hFF);
    check("cpu_100_data", 32'(col_data), 32'hF00);
    reg_address_in = a9(9'h1C0); data_in = 12'h456; slot();
    check("cpu_1c0_addr", 32'(col_address), 32'hFF);
    reg_address_in = a9(9'h1BE); data_in = 12'h0A5; slot();
    check("cpu_1be_addr", 32'(col_address), 32'hDF);
    check("cpu_1be_data", 32'(col_data), 32'h0A5);
    reg_address_in = 8'h00;

    // full 32-entry load
    begin_load(5'd0, 5'd31);
    check("full_busy0", 32'(busy), 32'h1);
    st_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      st_data = 12'(i);
      slot();
      check("full_addr", 32'(col_address), 32'hC0 + i);
      check("full_data", 32'(col_data), i);
      check("full_done", 32'(done), (i == 31) ? 32'h1 : 32'h0);
    end
    check("full_busy_end", 32'(busy), 32'h0);
    st_valid = 1'b0;
    slot();
    check("full_done_off", 32'(done), 32'h0);
    check("full_idle_addr", 32'(col_address), 32'hFF);

    // wrap 30,31,0,1 with a CPU write stealing the second slot
    begin_load(5'd30, 5'd3);
    st_valid = 1'b1; st_data = 12'h030; slot();
    check("wrap30_addr", 32'(col_address), 32'hDE);
    reg_address_in = a9(9'h1BC); data_in = 12'hABC; st_data = 12'h031; slot();
    check("arb_ready", 32'(last_rdy), 32'h0);
    check("arb_cpu_addr", 32'(col_address), 32'hDE);
    check("arb_cpu_data", 32'(col_data), 32'hABC);
    reg_address_in = 8'h00; slot();
    check("wrap31_addr", 32'(col_address), 32'hDF);
    check("wrap31_data", 32'(col_data), 32'h031);
    st_data = 12'h000; slot();
    check("wrap0_addr", 32'(col_address), 32'hC0);
    st_data = 12'h001; slot();
    check("wrap1_addr", 32'(col_address), 32'hC1);
    check("wrap_done", 32'(done), 32'h1);
    st_valid = 1'b0; slot();

    // stalls during a 4-entry load
    begin_load(5'd5, 5'd3);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      st_valid = pat[i];
      st_data = 12'h100 + 12'(k);
      slot();
      if (pat[i]) begin
        check("stall_addr", 32'(col_address), 32'hC5 + k);
        check("stall_data", 32'(col_data), 32'h100 + k);
        k++;
      end else begin
        check("stall_gap_addr", 32'(col_address), 32'hFF);
        check("stall_gap_busy", 32'(busy), 32'h1);
      end
    end
    check("stall_done", 32'(done), 32'h1);
    st_valid = 1'b0; slot();

    // abort after two of eight entries; start ignored while loading
    begin_load(5'd8, 5'd7);
    st_valid = 1'b1; start = 1'b1; start_index = 5'd20;
    st_data = 12'h200; slot();
    check("abort_e8", 32'(col_address), 32'hC8);
    st_data = 12'h201; slot();
    check("abort_e9", 32'(col_address), 32'hC9);
    start = 1'b0;
    abort = 1'b1; reg_address_in = a9(9'h1A0); data_in = 12'h777; slot();
    check("abort_cpu_addr", 32'(col_address), 32'hD0);
    check("abort_cpu_data", 32'(col_data), 32'h777);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    abort = 1'b0; reg_address_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      slot();
      check("abort_quiet", 32'(col_address), 32'hFF);
    end
    st_valid = 1'b0;
    begin_load(5'd2, 5'd0);
    st_valid = 1'b1; st_data = 12'h3C3; slot();
    check("restart_addr", 32'(col_address), 32'hC2);
    check("restart_done", 32'(done), 32'h1);
    st_valid = 1'b0; slot();

    // reset mid-load
    begin_load(5'd0, 5'd7);
    st_valid = 1'b1; st_data = 12'h555; slot(); slot();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_addr", 32'(col_address), 32'hFF);
    check("midrst_data", 32'(col_data), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ready", 32'(st_ready), 32'h0);
    slot(); slot();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slot();
      check("postrst_addr", 32'(col_address), 32'hFF);
      check("postrst_busy", 32'(busy), 32'h0);
    end
    st_valid = 1'b0;
    slot();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
